// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the CDC FIFO read-side blocks.
package cdc_pkg;

  localparam int unsigned CDC_STAT_W = 32;

  function automatic logic [CDC_STAT_W-1:0] cdc_sat_inc(input logic [CDC_STAT_W-1:0] cnt);
    if (&cnt) begin
      return cnt;
    end else begin
      return cnt + {{(CDC_STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/cdc_fifo_rd_unpack_if.sv
// FIFO read port plus outgoing beat stream of the read-side unpacker.
interface cdc_fifo_rd_unpack_if #(
  parameter int WIDTH_OUT = 8,
  parameter int RATIO     = 4
);
  localparam int WIDTH_IN = WIDTH_OUT * RATIO;

  logic                 fifo_rd_en_o;
  logic [WIDTH_IN-1:0]  fifo_rd_data_i;
  logic                 fifo_empty_i;
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic [WIDTH_OUT-1:0] m_data_o;
  logic                 m_last_o;

  modport master (
    output fifo_rd_en_o, m_valid_o, m_data_o, m_last_o,
    input  fifo_rd_data_i, fifo_empty_i, m_ready_i
  );

  modport slave (
    input  fifo_rd_en_o, m_valid_o, m_data_o, m_last_o,
    output fifo_rd_data_i, fifo_empty_i, m_ready_i
  );
endinterface

// File: rtl/cdc_rd_stats.sv
// Saturating popped-word and starved-cycle counters for the read unpacker.
// Present only when CDC_RD_STATS_EN is defined.
`ifdef CDC_RD_STATS_EN
module cdc_rd_stats
  import cdc_pkg::*;
(
  input  logic                  clk_rd,
  input  logic                  rst_rd,
  input  logic                  pop_i,
  input  logic                  starve_i,
  output logic [CDC_STAT_W-1:0] stat_words_o,
  output logic [CDC_STAT_W-1:0] stat_starve_o
);

  // Counter registers, cleared by the read-domain reset.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      stat_words_o  <= {CDC_STAT_W{1'b0}};
      stat_starve_o <= {CDC_STAT_W{1'b0}};
    end else begin
      if (pop_i) begin
        stat_words_o <= cdc_sat_inc(stat_words_o);
      end else begin
        stat_words_o <= stat_words_o;
      end
      if (starve_i) begin
        stat_starve_o <= cdc_sat_inc(stat_starve_o);
      end else begin
        stat_starve_o <= stat_starve_o;
      end
    end
  end

endmodule
`endif

// File: rtl/cdc_fifo_rd_unpack.sv
// Read-domain consumer of the async CDC FIFO: pops wide words and serialises them into beats.
// Optional statistics counters are enabled with CDC_RD_STATS_EN.
module cdc_fifo_rd_unpack
  import cdc_pkg::*;
#(
  parameter int WIDTH_OUT = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd,
  cdc_fifo_rd_unpack_if.master  bus
`ifdef CDC_RD_STATS_EN
  ,
  output logic [CDC_STAT_W-1:0] stat_words_o,
  output logic [CDC_STAT_W-1:0] stat_starve_o
`endif
);

  localparam int WIDTH_IN = WIDTH_OUT * RATIO;
  localparam int BEAT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RATIO - 1);

  if (RATIO < 1) begin : g_bad_ratio
    $error("cdc_fifo_rd_unpack: RATIO must be >= 1");
  end

  logic [WIDTH_IN-1:0]  word_r;
  logic                 word_vld_r;
  logic [BEAT_W-1:0]    beat_r;
  logic                 accept_s;
  logic                 final_s;
  logic                 pop_s;
  logic [BEAT_W-1:0]    slice_s;
  logic [WIDTH_OUT-1:0] m_data_s;

  assign accept_s = word_vld_r & bus.m_ready_i;
  assign final_s  = (beat_r == BEAT_LAST);
  // Pop refills the holding word on the very cycle its last beat leaves, so the stream stays bubble-free.
  assign pop_s    = ~rst_rd & ~bus.fifo_empty_i & (~word_vld_r | (accept_s & final_s));

  // Word-valid flag and beat index.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      word_vld_r <= 1'b0;
      beat_r     <= {BEAT_W{1'b0}};
    end else if (pop_s) begin
      word_vld_r <= 1'b1;
      beat_r     <= {BEAT_W{1'b0}};
    end else if (accept_s & final_s) begin
      word_vld_r <= 1'b0;
      beat_r     <= beat_r;
    end else if (accept_s) begin
      word_vld_r <= word_vld_r;
      beat_r     <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
    end else begin
      word_vld_r <= word_vld_r;
      beat_r     <= beat_r;
    end
  end

  // Holding register for the word being serialised; needs no reset since word_vld_r qualifies it.
  always_ff @(posedge clk_rd) begin
    if (pop_s) begin
      word_r <= bus.fifo_rd_data_i;
    end else begin
      word_r <= word_r;
    end
  end

  // Beat-to-slice mapping for the configured beat order.
  always_comb begin
    slice_s = beat_r;
    if (MSB_FIRST) begin
      slice_s = BEAT_LAST - beat_r;
    end else begin
      slice_s = beat_r;
    end
  end

  // Slice extraction from the holding register.
  always_comb begin
    m_data_s = WIDTH_OUT'(word_r >> (int'(slice_s) * WIDTH_OUT));
  end

  assign bus.fifo_rd_en_o = pop_s;
  assign bus.m_valid_o    = word_vld_r;
  assign bus.m_data_o     = m_data_s;
  assign bus.m_last_o     = word_vld_r & final_s;

`ifdef CDC_RD_STATS_EN
  cdc_rd_stats u_stats (
    .clk_rd        (clk_rd),
    .rst_rd        (rst_rd),
    .pop_i         (pop_s),
    .starve_i      (bus.m_ready_i & ~word_vld_r),
    .stat_words_o  (stat_words_o),
    .stat_starve_o (stat_starve_o)
  );
`endif

endmodule

// File: tb/tb_cdc_fifo_rd_unpack.sv
// Bench for cdc_fifo_rd_unpack: LSB-first and MSB-first instances share one FIFO and stream model.
module tb_cdc_fifo_rd_unpack;
  import cdc_pkg::*;

  localparam int WO    = 8;
  localparam int RATIO = 4;
  localparam int WI    = WO * RATIO;

  logic clk_rd = 1'b0;
  logic rst_rd;
  always #5 clk_rd = ~clk_rd;

  cdc_fifo_rd_unpack_if #(.WIDTH_OUT(WO), .RATIO(RATIO)) bus0 ();
  cdc_fifo_rd_unpack_if #(.WIDTH_OUT(WO), .RATIO(RATIO)) bus1 ();

`ifdef CDC_RD_STATS_EN
  logic [CDC_STAT_W-1:0] sw0, ss0, sw1, ss1;
`endif

  cdc_fifo_rd_unpack #(.WIDTH_OUT(WO), .RATIO(RATIO), .MSB_FIRST(1'b0)) dut0 (
    .clk_rd (clk_rd),
    .rst_rd (rst_rd),
    .bus    (bus0)
`ifdef CDC_RD_STATS_EN
    ,
    .stat_words_o  (sw0),
    .stat_starve_o (ss0)
`endif
  );

  cdc_fifo_rd_unpack #(.WIDTH_OUT(WO), .RATIO(RATIO), .MSB_FIRST(1'b1)) dut1 (
    .clk_rd (clk_rd),
    .rst_rd (rst_rd),
    .bus    (bus1)
`ifdef CDC_RD_STATS_EN
    ,
    .stat_words_o  (sw1),
    .stat_starve_o (ss1)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [WI-1:0] fq[$];
  logic [WI-1:0] cur_word;
  int            left;
  int unsigned   exp_words;
  int unsigned   exp_starve;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [WO-1:0] slice_of(input logic [WI-1:0] w, input int idx);
    return w[idx*WO +: WO];
  endfunction

  // One cycle: drive inputs at the falling edge, check after settling, advance the model at the rising edge.
  task automatic step(input bit rst, input bit rdy);
    bit            empty;
    bit            exp_valid;
    bit            accept;
    bit            exp_rd;
    bit            exp_last;
    bit            got_pop;
    int            b;
    logic [WI-1:0] head;

    empty = (fq.size() == 0);
    head  = empty ? 32'hDEAD_BEEF : fq[0];
    rst_rd              = rst;
    bus0.m_ready_i      = rdy;
    bus1.m_ready_i      = rdy;
    bus0.fifo_empty_i   = empty;
    bus1.fifo_empty_i   = empty;
    bus0.fifo_rd_data_i = head;
    bus1.fifo_rd_data_i = head;
    #1;

    exp_valid = (left > 0);
    accept    = exp_valid && rdy;
    exp_rd    = !rst && !empty && (!exp_valid || (accept && left == 1));
    exp_last  = exp_valid && (left == 1);
    b         = RATIO - left;

    check("rd_en_lsb", 32'(bus0.fifo_rd_en_o), 32'(exp_rd));
    check("rd_en_msb", 32'(bus1.fifo_rd_en_o), 32'(exp_rd));
    check("valid_lsb", 32'(bus0.m_valid_o), 32'(exp_valid));
    check("valid_msb", 32'(bus1.m_valid_o), 32'(exp_valid));
    check("last_lsb", 32'(bus0.m_last_o), 32'(exp_last));
    check("last_msb", 32'(bus1.m_last_o), 32'(exp_last));
    if (exp_valid) begin
      check("data_lsb", 32'(bus0.m_data_o), 32'(slice_of(cur_word, b)));
      check("data_msb", 32'(bus1.m_data_o), 32'(slice_of(cur_word, RATIO - 1 - b)));
    end
`ifdef CDC_RD_STATS_EN
    check("words_lsb", sw0, exp_words);
    check("words_msb", sw1, exp_words);
    check("starve_lsb", ss0, exp_starve);
    check("starve_msb", ss1, exp_starve);
`endif
    got_pop = bus0.fifo_rd_en_o;

    @(posedge clk_rd);
    if (rst) begin
      left       = 0;
      exp_words  = 0;
      exp_starve = 0;
    end else begin
      if (exp_rd) begin
        cur_word = head;
        left     = RATIO;
        exp_words++;
      end else if (accept) begin
        left--;
      end
      if (rdy && !exp_valid) exp_starve++;
    end
    if (got_pop && fq.size() > 0) void'(fq.pop_front());
    @(negedge clk_rd);
  endtask

  initial begin
    rst_rd              = 1'b1;
    bus0.m_ready_i      = 1'b0;
    bus1.m_ready_i      = 1'b0;
    bus0.fifo_empty_i   = 1'b1;
    bus1.fifo_empty_i   = 1'b1;
    bus0.fifo_rd_data_i = '0;
    bus1.fifo_rd_data_i = '0;
    left       = 0;
    cur_word   = '0;
    exp_words  = 0;
    exp_starve = 0;
    @(posedge clk_rd);
    @(negedge clk_rd);

    // Reset held with a non-empty FIFO, then release and drain.
    fq.push_back(32'h4433_2211);
    repeat (3) step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);

    // Two queued words stream back to back.
    fq.push_back(32'h4433_2211);
    fq.push_back(32'h8877_6655);
    repeat (10) step(1'b0, 1'b1);

    // Backpressure on the second beat.
    fq.push_back(32'h4433_2211);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);

    // Reset mid-word, then a fresh word.
    fq.push_back(32'h4433_2211);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    fq.push_back(32'hCCBB_AA99);
    repeat (6) step(1'b0, 1'b1);

    // Idle cycles with ready high.
    repeat (3) step(1'b0, 1'b1);

    // Randomised traffic, backpressure and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (fq.size() < 6 && $urandom_range(0, 3) == 0) fq.push_back($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
